booth_r4_seq_mult: RTL and testbench

Parametrised radix-4 Booth sequential multiplier, the next generation of the team's ASMD radix-2 Booth multiplier. It accepts an L_word × L_word operand pair on a Start/Ready handshake and processes two multiplier bits per cycle. A Signed_mode input selects two's-complement or unsigned operands, and it returns a 2·L_word product with a one-cycle Done pulse. It sits beside the datapath as a multi-cycle arithmetic unit: a shared controller issues operands and waits for Done.

---
 rtl/booth_r4_seq_mult_if.sv | 23 ++
 rtl/booth_r4_seq_mult.sv | 149 ++++++++++++++
 tb/tb_booth_r4_seq_mult.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_r4_seq_mult_if.sv
// Operand/result handshake bundle for booth_r4_seq_mult.
// The controller drives the master side and the multiplier is the slave.
interface booth_r4_seq_mult_if #(
    parameter int unsigned L_word = 8
);
    logic                  Start;
    logic                  Signed_mode;
    logic [L_word-1:0]     A;
    logic [L_word-1:0]     x;
    logic [2*L_word-1:0]   product;
    logic                  Ready;
    logic                  Done;

    modport master (
        output Start, Signed_mode, A, x,
        input  product, Ready, Done
    );

    modport slave (
        input  Start, Signed_mode, A, x,
        output product, Ready, Done
    );
endinterface

// File: rtl/booth_r4_seq_mult.sv
// Radix-4 Booth sequential multiplier: L_word x L_word -> 2*L_word, signed or unsigned.
// Optional macro BOOTH_EARLY_TERM_EN ends the run once all remaining Booth digits are zero.
module booth_r4_seq_mult #(
    parameter int unsigned L_word = 8
) (
    input  logic               clk,
    input  logic               reset,
    booth_r4_seq_mult_if.slave bus
);

    localparam int unsigned W  = L_word;
    localparam int unsigned PW = 2 * L_word;
    localparam int unsigned MW = 2 * L_word + 2;
    localparam int unsigned QW = L_word + 2;
    localparam int unsigned N  = L_word / 2 + 1;
    localparam int unsigned CW = $clog2(N + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q,   state_d;
    logic [MW-1:0] m_q,       m_d;
    logic [MW-1:0] acc_q,     acc_d;
    logic [QW-1:0] q_q,       q_d;
    logic          qm1_q,     qm1_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic [PW-1:0] product_q, product_d;
    logic          ready_q,   ready_d;
    logic          done_q,    done_d;

    logic          sign_a;
    logic          sign_x;
    logic          zero_op;
    logic [2:0]    triplet;
    logic [MW-1:0] sel;
    logic          sub;
    logic [MW-1:0] acc_sum;
    logic          last_digit;

    // Operand extension follows Signed_mode; a zero operand short-circuits to S_DONE
    always_comb begin
        sign_a  = bus.Signed_mode & bus.A[W-1];
        sign_x  = bus.Signed_mode & bus.x[W-1];
        zero_op = (bus.A == '0) || (bus.x == '0);
    end

    // Booth digit decode and accumulate; negative digits add the inverted multiple plus one
    always_comb begin
        triplet = {q_q[1:0], qm1_q};
        sel     = '0;
        sub     = 1'b0;
        case (triplet)
            3'b001, 3'b010: sel = m_q;
            3'b011:         sel = {m_q[MW-2:0], 1'b0};
            3'b100: begin
                sel = {m_q[MW-2:0], 1'b0};
                sub = 1'b1;
            end
            3'b101, 3'b110: begin
                sel = m_q;
                sub = 1'b1;
            end
            default: sel = '0;
        endcase
        acc_sum = acc_q + (sub ? ~sel : sel) + MW'(sub);
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        acc_d      = acc_q;
        q_d        = q_q;
        qm1_d      = qm1_q;
        cnt_d      = cnt_q;
        product_d  = product_q;
        last_digit = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    m_d   = {{(MW-W){sign_a}}, bus.A};
                    q_d   = {{(QW-W){sign_x}}, bus.x};
                    qm1_d = 1'b0;
                    acc_d = '0;
                    cnt_d = '0;
                    if (zero_op) begin
                        product_d = '0;
                        state_d   = S_DONE;
                    end else begin
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                acc_d = acc_sum;
                m_d   = {m_q[MW-3:0], 2'b00};
                qm1_d = q_q[1];
                q_d   = {{2{q_q[QW-1]}}, q_q[QW-1:2]};
                cnt_d = cnt_q + CW'(1);
                last_digit = (cnt_q == CW'(N - 1));
`ifdef BOOTH_EARLY_TERM_EN
                if (q_d == {QW{qm1_d}}) begin
                    last_digit = 1'b1;
                end
`endif
                if (last_digit) begin
                    product_d = acc_sum[PW-1:0];
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    assign bus.product = product_q;
    assign bus.Ready   = ready_q;
    assign bus.Done    = done_q;

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Self-checking bench for booth_r4_seq_mult: directed corners, random operands,
// reset/handshake boundaries, against an arithmetic reference model.
module tb_booth_r4_seq_mult;

    localparam int unsigned L_WORD = 8;
    localparam int unsigned N      = L_WORD / 2 + 1;

    logic clk = 1'b0;
    logic reset;

    booth_r4_seq_mult_if #(.L_word(L_WORD)) bus ();

    booth_r4_seq_mult #(.L_word(L_WORD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint ext(input logic [L_WORD-1:0] v, input logic sm);
        return sm ? longint'($signed(v)) : longint'(v);
    endfunction

    function automatic logic [2*L_WORD-1:0] ref_prod(input logic [L_WORD-1:0] a,
                                                     input logic [L_WORD-1:0] xv,
                                                     input logic sm);
        longint p;
        p = ext(a, sm) * ext(xv, sm);
        return p[2*L_WORD-1:0];
    endfunction

    // Cycles from accept edge until the sample where Done is seen
    function automatic int ref_lat(input logic [L_WORD-1:0] a,
                                   input logic [L_WORD-1:0] xv,
                                   input logic sm);
        longint xe;
        xe = ext(xv, sm);
        if (a == '0 || xv == '0) return 1;
`ifdef BOOTH_EARLY_TERM_EN
        for (int k = 1; k < int'(N); k++) begin
            if ((xe >>> (2 * k - 1)) == 0 || (xe >>> (2 * k - 1)) == -1) return k + 1;
        end
`else
        if (xe == 0) return 1;
`endif
        return int'(N) + 1;
    endfunction

    task automatic wait_ready();
        int c;
        c = 0;
        while (bus.Ready !== 1'b1 && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (bus.Ready !== 1'b1) check("ready_timeout", 64'(bus.Ready), 64'd1);
    endtask

    task automatic wait_done(output bit seen, output int lat);
        seen = 0;
        lat  = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (bus.Done === 1'b1) begin
                seen = 1;
                lat  = c;
            end
        end
    endtask

    task automatic do_op(input logic [L_WORD-1:0] a, input logic [L_WORD-1:0] xv,
                         input logic sm, input string tag);
        logic [2*L_WORD-1:0] prev;
        bit seen;
        int lat;
        wait_ready();
        prev            = bus.product;
        bus.Start       = 1'b1;
        bus.A           = a;
        bus.x           = xv;
        bus.Signed_mode = sm;
        @(posedge clk);
        #1;
        bus.Start       = 1'b0;
        bus.A           = L_WORD'($urandom);
        bus.x           = L_WORD'($urandom);
        bus.Signed_mode = 1'($urandom);
        @(negedge clk);
        if (bus.Done !== 1'b1) begin
            check({tag, "_hold"}, 64'(bus.product), 64'(prev));
            wait_done(seen, lat);
            lat = lat + 1;
        end else begin
            seen = 1;
            lat  = 1;
        end
        if (!seen) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            check({tag, "_product"}, 64'(bus.product), 64'(ref_prod(a, xv, sm)));
            check({tag, "_latency"}, 64'(lat), 64'(ref_lat(a, xv, sm)));
            @(negedge clk);
            check({tag, "_done_pulse"}, {62'd0, bus.Done, bus.Ready}, 64'b01);
            check({tag, "_stable"}, 64'(bus.product), 64'(ref_prod(a, xv, sm)));
        end
    endtask

    logic [L_WORD-1:0] qa[$];
    logic [L_WORD-1:0] qx[$];
    logic              qs[$];

    initial begin
        bit seen;
        int lat;
        int pulses;
        int dones;
        logic [L_WORD-1:0] ea, ex;
        logic              es;

        reset           = 1'b1;
        bus.Start       = 1'b0;
        bus.A           = '0;
        bus.x           = '0;
        bus.Signed_mode = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 64'(bus.Ready), 64'd1);
        check("rst_done", 64'(bus.Done), 64'd0);
        check("rst_product", 64'(bus.product), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed corners
        do_op(8'hFF, 8'hFF, 1'b0, "u_max");
        do_op(8'h80, 8'h80, 1'b1, "s_minmin");
        do_op(8'hFD, 8'h05, 1'b1, "s_neg3x5");
        do_op(8'h00, 8'd77, 1'b0, "zero_a");
        do_op(8'd7,  8'd1,  1'b1, "s_7x1");
        do_op(8'h80, 8'h7F, 1'b1, "s_minmax");
        do_op(8'hFF, 8'h80, 1'b1, "s_m1xmin");
        do_op(8'h7F, 8'h7F, 1'b1, "s_maxmax");
        do_op(8'd1,  8'h00, 1'b1, "zero_x");
        do_op(8'h80, 8'hFF, 1'b0, "u_128x255");

        // Random operands
        for (int i = 0; i < 40; i++) begin
            do_op(L_WORD'($urandom), L_WORD'($urandom), 1'($urandom), "rand");
        end

        // Reset in the third S_run cycle discards the result
        wait_ready();
        bus.Start = 1'b1; bus.A = 8'd100; bus.x = 8'd100; bus.Signed_mode = 1'b0;
        @(posedge clk);
        #1 bus.Start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_ready", 64'(bus.Ready), 64'd1);
        check("midrst_product", 64'(bus.product), 64'd0);
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.Done === 1'b1) pulses++;
            @(negedge clk);
        end
        check("midrst_no_done", 64'(pulses), 64'd0);
        do_op(8'd12, 8'd13, 1'b0, "post_rst");

        // Reset and Start on the same edge: reset wins
        bus.Start = 1'b1; bus.A = 8'd9; bus.x = 8'd9; reset = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0; reset = 1'b0;
        check("rst_start_ready", 64'(bus.Ready), 64'd1);
        check("rst_start_product", 64'(bus.product), 64'd0);
        @(negedge clk);
        check("rst_start_idle", {62'd0, bus.Done, bus.Ready}, 64'b01);

        // Start while busy is ignored
        wait_ready();
        bus.Start = 1'b1; bus.A = 8'h11; bus.x = 8'h22; bus.Signed_mode = 1'b0;
        @(posedge clk);
        #1 bus.A = 8'd3; bus.x = 8'd3;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 bus.Start = 1'b0;
        wait_done(seen, lat);
        check("busy_seen", 64'(seen), 64'd1);
        check("busy_product", 64'(bus.product), 64'h0242);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.Ready !== 1'b1 || bus.Done !== 1'b0) pulses++;
        end
        check("busy_no_requeue", 64'(pulses), 64'd0);

        // Start held high with operands changing every cycle
        wait_ready();
        dones = 0;
        bus.Start = 1'b1;
        for (int c = 0; c < 400 && dones < 30; c++) begin
            if (bus.Done === 1'b1) begin
                if (qa.size() == 0) begin
                    check("held_queue_empty", 64'd0, 64'd1);
                end else begin
                    ea = qa.pop_front();
                    ex = qx.pop_front();
                    es = qs.pop_front();
                    check("held_product", 64'(bus.product), 64'(ref_prod(ea, ex, es)));
                end
                dones++;
            end
            if (dones >= 30) begin
                bus.Start = 1'b0;
            end else begin
                bus.A           = ($urandom_range(0, 7) == 0) ? '0 : L_WORD'($urandom);
                bus.x           = ($urandom_range(0, 7) == 0) ? '0 : L_WORD'($urandom);
                bus.Signed_mode = 1'($urandom);
                if (bus.Ready === 1'b1) begin
                    qa.push_back(bus.A);
                    qx.push_back(bus.x);
                    qs.push_back(bus.Signed_mode);
                end
                @(negedge clk);
            end
        end
        bus.Start = 1'b0;
        check("held_done_count", 64'(dones), 64'd30);
        check("held_accepts_drained", 64'(qa.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
